trafficlight_nway: RTL

TRAFFICLIGHT_NWAY -- requirements
Module: trafficlight_nway

---
 rtl/trafficlight_nway.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/trafficlight_nway.sv
// Purpose : N-way round-robin traffic-light controller (GREEN -> YELLOW -> ALLRED per served way).
// Latency : all outputs are registered; a traffic change is reflected on the outputs one cycle later at the earliest.
// Backpressure: none; the block free-runs every cycle and traffic is a level-sensitive request vector.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high; forces way0 GREEN with timer 0
//   traffic    - per-way vehicle-present sensors, bit i = way i
//   light      - lamp drive, way i at [3i+2:3i] encoded {red,yellow,green}
//   active_way - index of the way owning the current phase (upper unused bits are 0)
//   phase      - 00 GREEN, 01 YELLOW, 10 ALLRED
module trafficlight_nway #(
    parameter int N_WAYS    = 4,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_WAYS-1:0]     traffic,
    output logic [3*N_WAYS-1:0]   light,
    output logic [2:0]            active_way,
    output logic [1:0]            phase
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (N_WAYS < 2 || N_WAYS > 8) begin : g_bad_nways
        $error("trafficlight_nway: N_WAYS must be in 2..8");
    end
    if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_green
        $error("trafficlight_nway: need 1 <= GREEN_MIN <= GREEN_MAX");
    end
    if (YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_clear
        $error("trafficlight_nway: YELLOW_T and ALLRED_T must be >= 1");
    end
    if (GREEN_MAX >= (1 << CNT_W) || YELLOW_T >= (1 << CNT_W) ||
        ALLRED_T >= (1 << CNT_W)) begin : g_bad_cntw
        $error("trafficlight_nway: time parameters must fit in CNT_W bits");
    end

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_e;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

    localparam logic [3*N_WAYS-1:0] LIGHT_RST = {{(N_WAYS-1){LAMP_R}}, LAMP_G};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [2:0]             way_q,   way_d;
    logic [3*N_WAYS-1:0]    light_q, light_d;

    // ------------------------------------------------------------------
    // Request view relative to the active way.
    // trf_rot[k] is the traffic bit of way (way_q + k) mod N_WAYS, so bit 0
    // is the owner and bits 1.. are the others in round-robin order.
    // ------------------------------------------------------------------
    logic [2*N_WAYS-1:0]    trf_dbl;
    logic [N_WAYS-1:0]      trf_rot;
    logic                   own_req;
    logic                   other_req;

    assign trf_dbl   = {traffic, traffic};
    assign trf_rot   = N_WAYS'(trf_dbl >> way_q);
    assign own_req   = trf_rot[0];
    assign other_req = |trf_rot[N_WAYS-1:1];

    // ------------------------------------------------------------------
    // Round-robin successor: nearest requesting way after the owner, or the
    // plain successor when nobody is waiting.
    // ------------------------------------------------------------------
    logic [3:0]             rr_off;
    logic [3:0]             rr_sum;
    logic [2:0]             rr_way;

    always_comb begin
        rr_off = 4'd1;
        // Descending scan so the smallest requesting offset wins.
        for (int k = N_WAYS - 1; k >= 1; k--) begin
            if (trf_rot[k]) begin
                rr_off = 4'(k);
            end
        end
        rr_sum = {1'b0, way_q} + rr_off;
        if (rr_sum >= 4'(N_WAYS)) begin
            rr_sum = rr_sum - 4'(N_WAYS);
        end
        rr_way = rr_sum[2:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        way_d   = way_q;

        case (state_q)
            ST_GREEN: begin
                // Only leave green when someone else is waiting: either the
                // owner has gone quiet after the minimum, or the maximum hit.
                if (other_req &&
                    (((timer_q >= GMIN_LAST) && !own_req) || (timer_q == GMAX_LAST))) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end else if (timer_q != GMAX_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_YELLOW: begin
                if (timer_q == YELLOW_LAST) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_ALLRED: begin
                if (timer_q == ALLRED_LAST) begin
                    state_d = ST_GREEN;
                    timer_d = '0;
                    way_d   = rr_way;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_GREEN;
                timer_d = '0;
                way_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lamp decode from the next state so the lamp register lines up with
    // state_q / way_q in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        light_d = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (3'(i) == way_d) begin
                case (state_d)
                    ST_GREEN:  light_d[3*i +: 3] = LAMP_G;
                    ST_YELLOW: light_d[3*i +: 3] = LAMP_Y;
                    default:   light_d[3*i +: 3] = LAMP_R;
                endcase
            end else begin
                light_d[3*i +: 3] = LAMP_R;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_GREEN;
            timer_q <= '0;
            way_q   <= '0;
            light_q <= LIGHT_RST;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            way_q   <= way_d;
            light_q <= light_d;
        end
    end

    assign light      = light_q;
    assign active_way = way_q;
    assign phase      = state_q;

endmodule
